// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end and the pattern detectors it
// feeds.
//   SER_IDLE / SER_SHIFT : serializer FSM state encoding (also exported on the
//                          debug state port)
//   SER_WIDTH            : default bit-stream word width
package serial_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH = 8;

endpackage

// File: rtl/bit_serializer_if.sv
// Bundles the word handshake and the serial output stream of bit_serializer.
//   din / din_valid / din_ready : word input, valid/ready handshake
//   x / x_valid                 : serial bit and its data/idle qualifier
//   word_done                   : pulse while the last bit of a word is on x
//   busy                        : shifter active or holding buffer occupied
// Handshake: a word transfers on a rising clk edge where din_valid and
// din_ready are both high; din is don't-care otherwise, and din_ready never
// depends on din_valid.
// Modports: master = word producer / stream consumer, slave = serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, word_done, busy
  );

endinterface

// File: rtl/word_hold_reg.sv
// One-entry holding buffer sitting in front of the shifter.
//   clk, rst : clock, asynchronous active-high reset
//   din      : word to capture
//   load     : capture din and mark the buffer full
//   unload   : the shifter took the held word; mark the buffer empty
//   dout     : held word
//   full     : buffer occupied
//   ready    : buffer can take a word this cycle (low while rst is high)
// load and unload are never high together: load needs ready (empty), unload
// only happens when full.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             unload,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             ready
);

  logic [WIDTH-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= din;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Combinational from rst so the producer sees "not ready" the moment
  // reset asserts, not one edge later.
  assign ready = !rst && !full;
  assign dout  = data;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over a valid/ready
// handshake and shifts them out on x, one bit per clk, with a one-word
// holding buffer so consecutive words leave with no gap.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : slave side of bit_serializer_if (word in, serial stream out)
//   state_dbg : current FSM state
// Parameters: WIDTH (2..32), LSB_FIRST (0 = MSB first), IDLE_BIT (x level
// while no word is being shifted).
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = SER_WIDTH,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  bit_serializer_if.slave         bus,
  output ser_state_t              state_dbg
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam int               OUT_IDX = (LSB_FIRST != 0) ? 0 : WIDTH - 1;

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             hold_ready;
  logic             accept;
  logic             load_point;
  logic             hold_load;
  logic             hold_unload;

  assign accept     = bus.din_valid && hold_ready;
  // Edge where the shifter can take a new word: it is empty, or its last
  // bit is on x right now.
  assign load_point = (state == SER_IDLE) || (cnt == LAST);
  // A held word always wins at a load point; an accept there can only
  // happen with the buffer empty, so it bypasses straight into shreg.
  assign hold_unload = load_point && hold_full;
  assign hold_load   = accept && !load_point;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .din    (bus.din),
    .load   (hold_load),
    .unload (hold_unload),
    .dout   (hold),
    .full   (hold_full),
    .ready  (hold_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SER_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (load_point) begin
      cnt <= '0;
      if (hold_full) begin
        shreg <= hold;
        state <= SER_SHIFT;
      end else if (accept) begin
        shreg <= bus.din;
        state <= SER_SHIFT;
      end else begin
        state <= SER_IDLE;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (LSB_FIRST != 0) shreg <= {1'b0, shreg[WIDTH-1:1]};
      else                shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  // All outputs decode registered state only; nothing here depends on din.
  assign bus.x         = (state == SER_SHIFT) ? shreg[OUT_IDX] : IDLE_BIT;
  assign bus.x_valid   = (state == SER_SHIFT);
  assign bus.word_done = (state == SER_SHIFT) && (cnt == LAST);
  assign bus.busy      = (state == SER_SHIFT) || hold_full;
  assign bus.din_ready = hold_ready;
  assign state_dbg     = state;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  import serial_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  bit_serializer_if #(.WIDTH(8)) bus_m ();
  bit_serializer_if #(.WIDTH(8)) bus_l ();
  ser_state_t st_m;
  ser_state_t st_l;

  bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .IDLE_BIT(1'b0)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_m),
    .state_dbg (st_m)
  );

  bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .IDLE_BIT(1'b0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_l),
    .state_dbg (st_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic x, input logic xv, input logic wd,
                         input logic ex, input logic ewd);
    check({tag, "_x"}, x, ex);
    check({tag, "_xv"}, xv, 1'b1);
    check({tag, "_wd"}, wd, ewd);
  endtask

  task automatic chk_idle_m(input string tag);
    check({tag, "_x"}, bus_m.x, 1'b0);
    check({tag, "_xv"}, bus_m.x_valid, 1'b0);
    check({tag, "_wd"}, bus_m.word_done, 1'b0);
  endtask

  logic [7:0]  exp8;
  logic [15:0] exp16;

  initial begin
    bus_m.din = '0; bus_m.din_valid = 1'b0;
    bus_l.din = '0; bus_l.din_valid = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk_idle_m("rst");
    check("rst_busy", bus_m.busy, 1'b0);
    check("rst_ready", bus_m.din_ready, 1'b0);
    check("rst_state", st_m, SER_IDLE);
    check("rst_ready_l", bus_l.din_ready, 1'b0);
    rst = 1'b0;
    #1 check("rel_ready", bus_m.din_ready, 1'b1);
    @(negedge clk);

    // single word, MSB first
    exp8 = 8'b10110100;
    bus_m.din = 8'hB4; bus_m.din_valid = 1'b1;
    @(negedge clk); bus_m.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk_bit("single", bus_m.x, bus_m.x_valid, bus_m.word_done, exp8[7-i], i == 7);
    end
    @(negedge clk);
    chk_idle_m("single_after");
    check("single_after_busy", bus_m.busy, 1'b0);

    // single word, LSB first
    exp8 = 8'b00101101;
    bus_l.din = 8'hB4; bus_l.din_valid = 1'b1;
    @(negedge clk); bus_l.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk_bit("lsb", bus_l.x, bus_l.x_valid, bus_l.word_done, exp8[7-i], i == 7);
    end
    @(negedge clk);
    check("lsb_after_xv", bus_l.x_valid, 1'b0);
    check("lsb_after_x", bus_l.x, 1'b0);

    // reset mid-word after 3 bits
    exp8 = 8'b10110100;
    bus_m.din = 8'hB4; bus_m.din_valid = 1'b1;
    @(negedge clk); bus_m.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk_bit("pre_rst", bus_m.x, bus_m.x_valid, bus_m.word_done, exp8[7-i], 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    chk_idle_m("async_rst");
    check("async_rst_busy", bus_m.busy, 1'b0);
    check("async_rst_ready", bus_m.din_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1 check("post_rst_ready", bus_m.din_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_idle_m("post_rst");
    end

    // back-to-back: second word waits in hold
    exp16 = 16'hA00F;
    bus_m.din = 8'hA0; bus_m.din_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk_bit("b2b", bus_m.x, bus_m.x_valid, bus_m.word_done, exp16[15-i], (i == 7) || (i == 15));
      if (i == 0) begin
        check("b2b_ready0", bus_m.din_ready, 1'b1);
        bus_m.din = 8'h0F;
      end else if (i == 1) begin
        check("b2b_hold_ready", bus_m.din_ready, 1'b0);
        check("b2b_busy", bus_m.busy, 1'b1);
        bus_m.din_valid = 1'b0;
      end else if (i == 7) begin
        check("b2b_ready7", bus_m.din_ready, 1'b0);
      end else if (i == 8) begin
        check("b2b_ready8", bus_m.din_ready, 1'b1);
      end
    end
    @(negedge clk);
    chk_idle_m("b2b_after");

    // bypass on the last-bit edge
    exp16 = 16'h3CFF;
    bus_m.din = 8'h3C; bus_m.din_valid = 1'b1;
    @(negedge clk); bus_m.din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk_bit("byp", bus_m.x, bus_m.x_valid, bus_m.word_done, exp16[15-i], (i == 7) || (i == 15));
      if (i == 7) begin
        check("byp_ready7", bus_m.din_ready, 1'b1);
        bus_m.din = 8'hFF; bus_m.din_valid = 1'b1;
      end else if (i == 8) begin
        bus_m.din_valid = 1'b0;
        check("byp_hold_empty", bus_m.din_ready, 1'b1);
      end
    end
    @(negedge clk);
    chk_idle_m("byp_after");

    // starvation: 5-cycle gap between words
    exp8 = 8'h81;
    bus_m.din = 8'h81; bus_m.din_valid = 1'b1;
    @(negedge clk); bus_m.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk_bit("starv_w1", bus_m.x, bus_m.x_valid, bus_m.word_done, exp8[7-i], i == 7);
    end
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk_idle_m("starv_gap");
      if (g == 4) begin
        bus_m.din = 8'h01; bus_m.din_valid = 1'b1;
      end
    end
    exp8 = 8'h01;
    @(negedge clk); bus_m.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk_bit("starv_w2", bus_m.x, bus_m.x_valid, bus_m.word_done, exp8[7-i], i == 7);
    end
    @(negedge clk);
    chk_idle_m("starv_after");
    check("starv_state", st_m, SER_IDLE);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
